// File: rtl/mult_seq.sv
// Signed 32x32 radix-2 Booth multiplier sequencer driving one add/sub alu.
// Optional MULT_SEQ_HI_OUT_EN exposes the upper product word as data_result_hi.
module mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef MULT_SEQ_HI_OUT_EN
    output logic [WIDTH-1:0] data_result_hi,
`endif
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0]       OP_ADD   = 5'b00000;
    localparam logic [4:0]       OP_SUB   = 5'b00001;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] m_r;
    logic             qm1_r;
    logic [CNT_W-1:0] count_r;

    logic [4:0]       alu_op_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_ovf_s;
    logic             alu_ne_unused_s;
    logic             alu_lt_unused_s;
    logic             alu_flags_unused_s;
    logic [WIDTH-1:0] sum_s;
    logic             ov_s;
    logic [WIDTH-1:0] hi_next_s;
    logic [WIDTH-1:0] lo_next_s;
    logic             exc_next_s;

    // True when the 64-bit product {hi, lo} is not a sign extension of lo.
    function automatic logic product_overflows(input logic [WIDTH-1:0] hi,
                                               input logic [WIDTH-1:0] lo);
        product_overflows = (hi != {WIDTH{lo[WIDTH-1]}});
    endfunction

    alu u_alu (
        .data_operandA  (hi_r),
        .data_operandB  (m_r),
        .ctrl_ALUopcode (alu_op_s),
        .ctrl_shiftamt  (5'd0),
        .data_result    (alu_result_s),
        .isNotEqual     (alu_ne_unused_s),
        .isLessThan     (alu_lt_unused_s),
        .overflow       (alu_ovf_s)
    );

    assign alu_flags_unused_s = alu_ne_unused_s ^ alu_lt_unused_s;

    // Booth recode of {lo[0], qm1} and the arithmetic shift of {hi, lo}.
    always_comb begin
        alu_op_s = OP_ADD;
        sum_s    = hi_r;
        ov_s     = 1'b0;
        case ({lo_r[0], qm1_r})
            2'b10: begin
                alu_op_s = OP_SUB;
                sum_s    = alu_result_s;
                ov_s     = alu_ovf_s;
            end
            2'b01: begin
                alu_op_s = OP_ADD;
                sum_s    = alu_result_s;
                ov_s     = alu_ovf_s;
            end
            default: begin
                alu_op_s = OP_ADD;
                sum_s    = hi_r;
                ov_s     = 1'b0;
            end
        endcase
        // Overflow flips the sign so hi +/- M behaves as a 33-bit value.
        hi_next_s  = {sum_s[WIDTH-1] ^ ov_s, sum_s[WIDTH-1:1]};
        lo_next_s  = {sum_s[0], lo_r[WIDTH-1:1]};
        exc_next_s = product_overflows(hi_next_s, lo_next_s);
    end

    // Sequencer state, Booth registers and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            busy           <= 1'b0;
            hi_r           <= '0;
            lo_r           <= '0;
            m_r            <= '0;
            qm1_r          <= 1'b0;
            count_r        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef MULT_SEQ_HI_OUT_EN
            data_result_hi <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ctrl_MULT) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        m_r     <= data_operandA;
                        hi_r    <= '0;
                        lo_r    <= data_operandB;
                        qm1_r   <= 1'b0;
                        count_r <= '0;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    if (count_r == LAST_CNT) begin
                        data_result    <= lo_next_s;
                        data_exception <= exc_next_s;
                        data_resultRDY <= 1'b1;
`ifdef MULT_SEQ_HI_OUT_EN
                        data_result_hi <= hi_next_s;
`endif
                    end else begin
                        data_resultRDY <= 1'b0;
                    end
                    // A new start always wins over the step, even on the completion edge.
                    if (ctrl_MULT) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        m_r     <= data_operandA;
                        hi_r    <= '0;
                        lo_r    <= data_operandB;
                        qm1_r   <= 1'b0;
                        count_r <= '0;
                    end else if (count_r == LAST_CNT) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        hi_r    <= hi_next_s;
                        lo_r    <= lo_next_s;
                        qm1_r   <= lo_r[0];
                        count_r <= count_r + CNT_W'(1);
                    end else begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        hi_r    <= hi_next_s;
                        lo_r    <= lo_next_s;
                        qm1_r   <= lo_r[0];
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// Team 32-bit ALU: add, sub, and, or, sll, sra with signed overflow and compare flags.
module alu (
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic        add_ovf_s;
    logic        sub_ovf_s;

    assign sum_s     = data_operandA + data_operandB;
    assign diff_s    = data_operandA - data_operandB;
    assign add_ovf_s = (data_operandA[31] == data_operandB[31]) && (sum_s[31] != data_operandA[31]);
    assign sub_ovf_s = (data_operandA[31] != data_operandB[31]) && (diff_s[31] != data_operandA[31]);
    assign isNotEqual = (diff_s != 32'd0);
    assign isLessThan = diff_s[31] ^ sub_ovf_s;

    // Opcode decode; only add and sub report overflow.
    always_comb begin
        data_result = sum_s;
        overflow    = 1'b0;
        case (ctrl_ALUopcode)
            5'b00000: begin data_result = sum_s;  overflow = add_ovf_s; end
            5'b00001: begin data_result = diff_s; overflow = sub_ovf_s; end
            5'b00010: begin data_result = data_operandA & data_operandB; overflow = 1'b0; end
            5'b00011: begin data_result = data_operandA | data_operandB; overflow = 1'b0; end
            5'b00100: begin data_result = data_operandA << ctrl_shiftamt; overflow = 1'b0; end
            5'b00101: begin data_result = $signed(data_operandA) >>> ctrl_shiftamt; overflow = 1'b0; end
            default:  begin data_result = sum_s;  overflow = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq: latency, results, restart, reset, back-to-back.
module tb_mult_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef MULT_SEQ_HI_OUT_EN
    logic [31:0] data_result_hi;
`endif

    int errors = 0;
    int checks = 0;

    mult_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef MULT_SEQ_HI_OUT_EN
        .data_result_hi (data_result_hi),
`endif
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Ticks until ready is seen; n is the number of edges taken (61 on timeout).
    task automatic wait_ready(output int n, output bit busy_dropped);
        busy_dropped = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (data_resultRDY) begin
                n = i;
                return;
            end
            if (!busy) busy_dropped = 1'b1;
        end
        n = 61;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT     = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'hCAFE_F00D;
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_lo, input logic exp_exc,
                            input logic [31:0] exp_hi);
        int  n;
        bit  dropped;
        start(a, b);
        check_value({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        wait_ready(n, dropped);
        check_value({tag, " latency"}, n, 32'd32);
        check_value({tag, " busy_held"}, {31'd0, dropped}, 32'd0);
        check_value({tag, " result"}, data_result, exp_lo);
        check_value({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
        check_value({tag, " busy_done"}, {31'd0, busy}, 32'd0);
`ifdef MULT_SEQ_HI_OUT_EN
        check_value({tag, " result_hi"}, data_result_hi, exp_hi);
`else
        if (exp_hi == 32'hFFFF_FFFF) begin
            check_value({tag, " hi_sign"}, {31'd0, data_result[31]}, 32'd1);
        end else begin
            check_value({tag, " hi_sign"}, {31'd0, data_result[31] & ~data_exception}, 32'd0);
        end
`endif
        tick();
        check_value({tag, " ready_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
        check_value({tag, " result_held"}, data_result, exp_lo);
    endtask

    initial begin
        int  pulses;
        int  pulse_edge;
        int  n;
        bit  dropped;
        logic [31:0] seen;

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        tick();
        tick();
        check_value("rst busy", {31'd0, busy}, 32'd0);
        check_value("rst ready", {31'd0, data_resultRDY}, 32'd0);
        check_value("rst result", data_result, 32'd0);
        check_value("rst exception", {31'd0, data_exception}, 32'd0);
        reset = 1'b0;
        tick();

        run_mult("3x5",        32'd3,          32'd5,          32'h0000_000F, 1'b0, 32'h0000_0000);
        run_mult("-7x6",       32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6, 1'b0, 32'hFFFF_FFFF);
        run_mult("min_x1",     32'h8000_0000,  32'd1,          32'h8000_0000, 1'b0, 32'hFFFF_FFFF);
        run_mult("min_xm1",    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 32'h0000_0000);
        run_mult("max_x2",     32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE, 1'b1, 32'h0000_0000);
        run_mult("2p16sq",     32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1, 32'h0000_0001);
        run_mult("m1xm1",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 32'h0000_0000);
        run_mult("zero",       32'd0,          32'h8000_0000,  32'h0000_0000, 1'b0, 32'h0000_0000);

        // Restart at edge 10 with 4x4: single ready pulse at edge 42.
        start(32'd3, 32'd5);
        for (int e = 1; e <= 9; e++) tick();
        start(32'd4, 32'd4);
        pulses = 0;
        pulse_edge = 0;
        seen = 32'd0;
        for (int e = 11; e <= 50; e++) begin
            tick();
            if (data_resultRDY) begin
                pulses++;
                pulse_edge = e;
                seen = data_result;
            end
        end
        check_value("restart pulses", pulses, 32'd1);
        check_value("restart edge", pulse_edge, 32'd42);
        check_value("restart result", seen, 32'h0000_0010);

        // Reset asserted at edge 20 of a run.
        start(32'd3, 32'd5);
        for (int e = 1; e <= 19; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("midrst busy", {31'd0, busy}, 32'd0);
        check_value("midrst ready", {31'd0, data_resultRDY}, 32'd0);
        check_value("midrst result", data_result, 32'd0);
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (data_resultRDY) pulses++;
        end
        check_value("midrst no_pulse", pulses, 32'd0);

        // Back-to-back: second start on the completion edge of the first.
        start(32'd3, 32'd5);
        for (int e = 1; e <= 31; e++) tick();
        start(32'hFFFF_FFF9, 32'd6);
        check_value("b2b ready1", {31'd0, data_resultRDY}, 32'd1);
        check_value("b2b result1", data_result, 32'h0000_000F);
        check_value("b2b busy", {31'd0, busy}, 32'd1);
        wait_ready(n, dropped);
        check_value("b2b latency2", n, 32'd32);
        check_value("b2b result2", data_result, 32'hFFFF_FFD6);
        check_value("b2b exception2", {31'd0, data_exception}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Multi-cycle sequencer that computes signed 32x32 multiplication by driving the team's 32-bit add/sub `alu` (one instance inside this block) through 32 radix-2 Booth iterations. It provides the multiply side of the processor's multdiv unit. Handshake: start pulse in, one-cycle ready pulse out. The result is the low 32 bits of the product, plus an exception flag when the signed product does not fit in 32 bits.

Parameters:
- WIDTH, 32, operand/result width; must match the `alu` datapath (only 32 supported).
- CNT_W, 6, iteration counter width (holds 0..WIDTH).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- ctrl_MULT  input  1  start pulse; sampled each rising edge.
- data_operandA  input  32  multiplicand, signed; sampled only when ctrl_MULT=1.
- data_operandB  input  32  multiplier, signed; sampled only when ctrl_MULT=1.
- data_result  output  32  low 32 bits of the product, registered.
- data_exception  output  1  signed product outside the 32-bit range, registered.
- data_resultRDY  output  1  one-cycle completion pulse, registered.
- busy  output  1  high while iterating.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset has priority over everything and may arrive mid-operation.
  - On reset: state=IDLE, busy=0, data_resultRDY=0, data_result=0, data_exception=0, count=0, internal registers hi/lo/M/qm1 = 0.
- States:
  - IDLE: busy=0. ctrl_MULT=1 at an edge loads M=A, hi=0, lo=B, qm1=0, count=0, then goes to RUN.
  - RUN: busy=1. One Booth step per edge; count increments.
  - On the edge where count reaches 32: return to IDLE, latch outputs, set data_resultRDY=1.
- Booth step (one per RUN edge), using the shared `alu`:
  - alu A=hi, B=M, ctrl_shiftamt=0.
  - Op selected by {lo[0],qm1}:
    - 10: ctrl_ALUopcode=00001 (sub); sum=alu result, ov=alu overflow.
    - 01: ctrl_ALUopcode=00000 (add); sum=alu result, ov=alu overflow.
    - 00 or 11: sum=hi, ov=0. Drive the alu opcode as 00000; its result is ignored.
  - new_sign = sum[31] XOR ov. This corrects the sign when hi±M overflows, e.g. M=0x80000000.
  - Register updates: hi <= {new_sign, sum[31:1]}; lo <= {sum[0], lo[31:1]}; qm1 <= lo[0].
- Completion (at the 32nd RUN edge, using post-step values):
  - data_result <= lo.
  - data_exception <= 1 iff hi is not all copies of lo[31].
  - data_resultRDY <= 1.
- Latency:
  - ctrl_MULT sampled at edge 0 → data_resultRDY high from edge 32 to edge 33, exactly one cycle.
  - data_result and data_exception hold their values until the next completion or reset.
- ctrl_MULT while busy=1: restart. The new operands are loaded and count=0; the previous operation is discarded with no ready pulse for it.
- ctrl_MULT on the same edge that completes an operation: the completion still latches and pulses ready, and the new operation starts (busy=1 next cycle).
- ctrl_MULT while busy=0 and data_resultRDY=1: accepted normally.
- The alu's isNotEqual and isLessThan outputs are unused.

Optional Feature:
- Macro: MULT_SEQ_HI_OUT_EN.
- Defined: adds output port data_result_hi (32 bits), registered at completion to the post-step hi. Its reset value is 0 and it is held like data_result. {data_result_hi, data_result} is then the full signed 64-bit product.
- Undefined: the port does not exist; hi is internal only. All other behaviour is identical.

Test Plan:
- A=3, B=5, ctrl_MULT pulse at edge 0 → busy 1 through edge 32; data_resultRDY high exactly one cycle after edge 32; result 0x0000000F, exception 0.
- A=-7, B=6 → result 0xFFFFFFD6, exception 0 (with the macro: hi=0xFFFFFFFF).
- A=0x80000000, B=1 → result 0x80000000, exception 0 (exercises the alu-overflow sign fix). A=0x80000000, B=-1 → result 0x80000000, exception 1.
- A=0x7FFFFFFF, B=2 → result 0xFFFFFFFE, exception 1. A=0x00010000, B=0x00010000 → result 0, exception 1.
- Start A=3, B=5; at edge 10 pulse ctrl_MULT with A=4, B=4 → exactly one ready pulse, after edge 42, result 0x10. Assert reset at edge 20 of a run → next cycle busy=0, ready=0, result=0, no later ready pulse.
- Back-to-back: new ctrl_MULT on the completion edge → ready pulses for both, 32 cycles apart, with correct results for each.
